injector_scheduler: RTL and testbench

INJECTOR_SCHEDULER -- requirements
Module: injector_scheduler

---
 rtl/injector_scheduler_if.sv | 23 ++
 rtl/injector_scheduler.sv | 140 ++++++++++++++
 tb/tb_injector_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/injector_scheduler_if.sv
// Command handshake between a sequencer and the injector scheduler.
// One command per accepted valid/ready beat: target channel, peak and total width in ticks.
interface injector_scheduler_if #(
   parameter int unsigned NCH = 4
);
   localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic          i_cmd_valid;
   logic          o_cmd_ready;
   logic [CW-1:0] i_cmd_chan;
   logic [15:0]   i_cmd_peak;
   logic [15:0]   i_cmd_width;

   modport master (
      output i_cmd_valid, i_cmd_chan, i_cmd_peak, i_cmd_width,
      input  o_cmd_ready
   );

   modport slave (
      input  i_cmd_valid, i_cmd_chan, i_cmd_peak, i_cmd_width,
      output o_cmd_ready
   );
endinterface

// File: rtl/injector_scheduler.sv
// Per-channel injector pulse sequencer: peak phase then hold phase, timed in prescaled ticks,
// with per-channel abort and a shared free-running chop strobe.
module injector_scheduler #(
   parameter int unsigned NCH      = 4,
   parameter int unsigned TICK_DIV = 50,
   parameter int unsigned CHOP_DIV = 20
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   injector_scheduler_if.slave  cmd,
   input  logic [NCH-1:0]       i_abort,
   output logic [NCH-1:0]       o_enable,
   output logic [NCH-1:0]       o_peak,
   output logic [NCH-1:0]       o_hold,
   output logic                 o_period,
   output logic [NCH-1:0]       o_done,
   output logic [NCH-1:0]       o_busy
);
   localparam int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [15:0] CHOP_LAST = 16'(CHOP_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_PEAK, S_HOLD} state_t;

   state_t      state_q [NCH];
   state_t      state_d [NCH];
   logic [15:0] presc_q [NCH];
   logic [15:0] presc_d [NCH];
   logic [15:0] tick_q  [NCH];
   logic [15:0] tick_d  [NCH];
   logic [15:0] peak_q  [NCH];
   logic [15:0] peak_d  [NCH];
   logic [15:0] width_q [NCH];
   logic [15:0] width_d [NCH];
   logic [15:0] tick_inc [NCH];
   logic        tick_end [NCH];
   logic [NCH-1:0] done_d;
   logic [15:0] chop_q;
   logic [15:0] chop_d;
   logic        period_d;
   logic        chan_ok;
   logic        accept;

   // Ready depends only on the addressed channel's busy/abort state, never on valid.
   always_comb begin
      chan_ok         = 32'(cmd.i_cmd_chan) < NCH;
      cmd.o_cmd_ready = 1'b0;
      if (chan_ok) begin
         cmd.o_cmd_ready = !o_busy[cmd.i_cmd_chan] && !i_abort[cmd.i_cmd_chan];
      end
      accept = cmd.i_cmd_valid && cmd.o_cmd_ready;
   end

   // Next-state for every channel plus the shared chop counter.
   always_comb begin
      chop_d   = (chop_q == CHOP_LAST) ? 16'd0 : chop_q + 16'd1;
      period_d = (chop_q == CHOP_LAST);
      done_d   = '0;
      for (int n = 0; n < NCH; n++) begin
         state_d[n]  = state_q[n];
         presc_d[n]  = presc_q[n];
         tick_d[n]   = tick_q[n];
         peak_d[n]   = peak_q[n];
         width_d[n]  = width_q[n];
         tick_inc[n] = tick_q[n] + 16'd1;
         tick_end[n] = (presc_q[n] == TICK_LAST);
         case (state_q[n])
            S_IDLE: begin
               if (accept && cmd.i_cmd_chan == CW'(n)) begin
                  presc_d[n] = 16'd0;
                  tick_d[n]  = 16'd0;
                  peak_d[n]  = cmd.i_cmd_peak;
                  width_d[n] = cmd.i_cmd_width;
                  if (cmd.i_cmd_width == 16'd0) begin
                     done_d[n] = 1'b1;
                  end else if (cmd.i_cmd_peak == 16'd0) begin
                     state_d[n] = S_HOLD;
                  end else begin
                     state_d[n] = S_PEAK;
                  end
               end
            end
            S_PEAK, S_HOLD: begin
               if (i_abort[n]) begin
                  state_d[n] = S_IDLE;
                  done_d[n]  = 1'b1;
               end else if (tick_end[n]) begin
                  presc_d[n] = 16'd0;
                  tick_d[n]  = tick_inc[n];
                  // Width expiry wins over the peak boundary when peak >= width.
                  if (tick_inc[n] == width_q[n]) begin
                     state_d[n] = S_IDLE;
                     done_d[n]  = 1'b1;
                  end else if (state_q[n] == S_PEAK && tick_inc[n] == peak_q[n]) begin
                     state_d[n] = S_HOLD;
                  end
               end else begin
                  presc_d[n] = presc_q[n] + 16'd1;
               end
            end
            default: state_d[n] = S_IDLE;
         endcase
      end
   end

   // State and registered outputs; outputs follow the next state so they align with it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int n = 0; n < NCH; n++) begin
            state_q[n] <= S_IDLE;
            presc_q[n] <= 16'd0;
            tick_q[n]  <= 16'd0;
            peak_q[n]  <= 16'd0;
            width_q[n] <= 16'd0;
         end
         o_enable <= '0;
         o_peak   <= '0;
         o_hold   <= '0;
         o_busy   <= '0;
         o_done   <= '0;
         o_period <= 1'b0;
         chop_q   <= 16'd0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            state_q[n]  <= state_d[n];
            presc_q[n]  <= presc_d[n];
            tick_q[n]   <= tick_d[n];
            peak_q[n]   <= peak_d[n];
            width_q[n]  <= width_d[n];
            o_enable[n] <= (state_d[n] != S_IDLE);
            o_busy[n]   <= (state_d[n] != S_IDLE);
            o_peak[n]   <= (state_d[n] == S_PEAK);
            o_hold[n]   <= (state_d[n] == S_HOLD);
         end
         o_done   <= done_d;
         o_period <= period_d;
         chop_q   <= chop_d;
      end
   end
endmodule

// File: tb/tb_injector_scheduler.sv
// Bench for injector_scheduler: directed pulse/abort/reset scenarios plus random traffic,
// all checked against an edge-indexed model of each channel's pulse window.
module tb_injector_scheduler;
   localparam int unsigned NCH = 4;
   localparam int unsigned TD  = 4;
   localparam int unsigned CD  = 5;
   localparam int unsigned CW  = 2;

   logic           i_clk = 1'b0;
   logic           i_rst;
   logic [NCH-1:0] i_abort;
   logic [NCH-1:0] o_enable, o_peak, o_hold, o_done, o_busy;
   logic           o_period;

   injector_scheduler_if #(.NCH(NCH)) cmd_if ();

   injector_scheduler #(.NCH(NCH), .TICK_DIV(TD), .CHOP_DIV(CD)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .cmd      (cmd_if.slave),
      .i_abort  (i_abort),
      .o_enable (o_enable),
      .o_peak   (o_peak),
      .o_hold   (o_hold),
      .o_period (o_period),
      .o_done   (o_done),
      .o_busy   (o_busy)
   );

   always #10 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   // Model: edge counter since reset release; per channel the accept edge, end edge, peak end edge.
   int e = 0;
   bit have  [NCH];
   int e0    [NCH];
   int eend  [NCH];
   int pkend [NCH];
   bit acc_last;
   int n_en [NCH];
   int n_pk [NCH];
   int n_hd [NCH];
   int n_dn [NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   function automatic bit m_busy(input int ch);
      return have[ch] && e >= e0[ch] && e < eend[ch];
   endfunction

   function automatic bit m_ready(input int ch);
      return (ch < int'(NCH)) && !m_busy(ch) && !i_abort[ch];
   endfunction

   task automatic clr_cnt();
      for (int i = 0; i < int'(NCH); i++) begin
         n_en[i] = 0; n_pk[i] = 0; n_hd[i] = 0; n_dn[i] = 0;
      end
   endtask

   task automatic step();
      int ch, p, w, pk;
      bit acc;
      bit [NCH-1:0] ab;
      logic [NCH-1:0] x_en, x_pk, x_hd, x_dn;
      @(negedge i_clk);
      ch = int'(cmd_if.i_cmd_chan);
      chk("cmd_ready", 32'(cmd_if.o_cmd_ready), 32'(m_ready(ch)));
      acc = cmd_if.i_cmd_valid && m_ready(ch);
      p = int'(cmd_if.i_cmd_peak);
      w = int'(cmd_if.i_cmd_width);
      for (int i = 0; i < int'(NCH); i++) ab[i] = i_abort[i] && m_busy(i);
      @(posedge i_clk);
      #1;
      e++;
      if (acc) begin
         pk        = (p < w) ? p : w;
         have[ch]  = 1'b1;
         e0[ch]    = e;
         eend[ch]  = e + w * int'(TD);
         pkend[ch] = e + pk * int'(TD);
      end
      for (int i = 0; i < int'(NCH); i++) if (ab[i]) eend[i] = e;
      for (int i = 0; i < int'(NCH); i++) begin
         x_en[i] = have[i] && e >= e0[i] && e < eend[i];
         x_pk[i] = x_en[i] && e < pkend[i];
         x_hd[i] = x_en[i] && !x_pk[i];
         x_dn[i] = have[i] && e == eend[i];
      end
      chk("enable", 32'(o_enable), 32'(x_en));
      chk("peak",   32'(o_peak),   32'(x_pk));
      chk("hold",   32'(o_hold),   32'(x_hd));
      chk("done",   32'(o_done),   32'(x_dn));
      chk("busy",   32'(o_busy),   32'(x_en));
      chk("period", 32'(o_period), 32'((e % int'(CD)) == 0));
      for (int i = 0; i < int'(NCH); i++) begin
         n_en[i] += int'(o_enable[i]);
         n_pk[i] += int'(o_peak[i]);
         n_hd[i] += int'(o_hold[i]);
         n_dn[i] += int'(o_done[i]);
      end
      acc_last = acc;
   endtask

   task automatic offer(input int ch, input int p, input int w, input int budget);
      bit got = 1'b0;
      cmd_if.i_cmd_valid = 1'b1;
      cmd_if.i_cmd_chan  = CW'(ch);
      cmd_if.i_cmd_peak  = 16'(p);
      cmd_if.i_cmd_width = 16'(w);
      for (int k = 0; k < budget && !got; k++) begin
         step();
         got = acc_last;
      end
      cmd_if.i_cmd_valid = 1'b0;
      chk("accept_timeout", 32'(got), 32'd1);
   endtask

   // Asserts reset between edges, checks the asynchronous clear, releases just after an edge.
   task automatic do_reset();
      i_rst = 1'b1;
      #1;
      chk("rst_enable", 32'(o_enable), 32'd0);
      chk("rst_peak",   32'(o_peak),   32'd0);
      chk("rst_hold",   32'(o_hold),   32'd0);
      chk("rst_done",   32'(o_done),   32'd0);
      chk("rst_busy",   32'(o_busy),   32'd0);
      chk("rst_period", 32'(o_period), 32'd0);
      cmd_if.i_cmd_valid = 1'b0;
      i_abort = '0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      e = 0;
      for (int i = 0; i < int'(NCH); i++) have[i] = 1'b0;
   endtask

   initial begin
      int k;
      i_rst = 1'b0;
      i_abort = '0;
      cmd_if.i_cmd_valid = 1'b0;
      cmd_if.i_cmd_chan  = '0;
      cmd_if.i_cmd_peak  = '0;
      cmd_if.i_cmd_width = '0;
      #1;
      do_reset();

      // Every channel ready straight out of reset.
      for (int ch = 0; ch < int'(NCH); ch++) begin
         cmd_if.i_cmd_chan = CW'(ch);
         #1;
         chk("ready_after_reset", 32'(cmd_if.o_cmd_ready), 32'd1);
      end

      // Peak 3 / width 10 on channel 0.
      clr_cnt();
      offer(0, 3, 10, 4);
      k = 0;
      while (!o_done[0] && k < 60) begin step(); k++; end
      chk("ch0_done_seen", 32'(o_done[0]), 32'd1);
      step();
      chk("ch0_enable_len", 32'(n_en[0]), 32'd40);
      chk("ch0_peak_len",   32'(n_pk[0]), 32'd12);
      chk("ch0_hold_len",   32'(n_hd[0]), 32'd28);
      chk("ch0_done_cnt",   32'(n_dn[0]), 32'd1);

      // Zero peak, then peak longer than width, on channel 1.
      clr_cnt();
      offer(1, 0, 5, 4);
      repeat (24) step();
      chk("ch1_p0_peak_len", 32'(n_pk[1]), 32'd0);
      chk("ch1_p0_hold_len", 32'(n_hd[1]), 32'd20);
      chk("ch1_p0_en_len",   32'(n_en[1]), 32'd20);
      clr_cnt();
      offer(1, 9, 5, 4);
      repeat (24) step();
      chk("ch1_p9_peak_len", 32'(n_pk[1]), 32'd20);
      chk("ch1_p9_hold_len", 32'(n_hd[1]), 32'd0);
      chk("ch1_p9_done_cnt", 32'(n_dn[1]), 32'd1);

      // Zero width completes at once; a command to a busy channel waits for it to finish.
      clr_cnt();
      offer(0, 5, 5, 4);
      offer(2, 0, 0, 4);
      repeat (2) step();
      chk("ch2_w0_enable", 32'(n_en[2]), 32'd0);
      chk("ch2_w0_done",   32'(n_dn[2]), 32'd1);
      offer(0, 1, 2, 40);
      chk("ch0_wait_prev_done", 32'(n_dn[0]), 32'd1);
      repeat (10) step();

      // Abort seven clocks into hold on channel 3.
      clr_cnt();
      offer(3, 2, 10, 4);
      k = 0;
      while (!o_hold[3] && k < 20) begin step(); k++; end
      chk("ch3_hold_seen", 32'(o_hold[3]), 32'd1);
      repeat (6) step();
      i_abort[3] = 1'b1;
      step();
      i_abort[3] = 1'b0;
      repeat (3) step();
      chk("ch3_abort_en_len",   32'(n_en[3]), 32'd15);
      chk("ch3_abort_hold_len", 32'(n_hd[3]), 32'd7);
      chk("ch3_abort_done_cnt", 32'(n_dn[3]), 32'd1);

      // Abort on the very edge the pulse expires.
      clr_cnt();
      offer(3, 0, 3, 4);
      repeat (11) step();
      i_abort[3] = 1'b1;
      step();
      i_abort[3] = 1'b0;
      repeat (3) step();
      chk("ch3_expiry_abort_en_len",   32'(n_en[3]), 32'd12);
      chk("ch3_expiry_abort_done_cnt", 32'(n_dn[3]), 32'd1);

      // Abort on an idle channel does nothing.
      clr_cnt();
      i_abort[2] = 1'b1;
      repeat (2) step();
      i_abort[2] = 1'b0;
      chk("idle_abort_done_cnt", 32'(n_dn[2]), 32'd0);

      // Reset in the middle of a pulse: no completion strobe afterwards.
      offer(0, 2, 8, 4);
      repeat (5) step();
      do_reset();
      clr_cnt();
      repeat (12) step();
      chk("post_reset_done_cnt", 32'(n_dn[0]), 32'd0);

      // Random traffic against the model.
      for (int it = 0; it < 400; it++) begin
         cmd_if.i_cmd_valid = 1'($urandom_range(0, 1));
         cmd_if.i_cmd_chan  = CW'($urandom_range(0, NCH - 1));
         cmd_if.i_cmd_peak  = 16'($urandom_range(0, 6));
         cmd_if.i_cmd_width = 16'($urandom_range(0, 8));
         for (int i = 0; i < int'(NCH); i++) i_abort[i] = ($urandom_range(0, 24) == 0);
         step();
      end
      cmd_if.i_cmd_valid = 1'b0;
      i_abort = '0;
      repeat (40) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
